// File: rtl/rdmem_port_arbiter.sv
// Round-robin arbiter sharing one in-order read port between fetch (F) and ReadMem (M); owner FIFO routes responses back.
// Latency: request path combinational; response 1 cycle after mem_rsp_valid (registered).
// Backpressure: grant locks while memory stalls; both readies drop when MAX_OUT reads are in flight. Optional RDMEM_ARB_PERF_EN adds perf counters.

module rdmem_owner_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) store[wr_ptr] <= push_dat;
    end

    assign pop_dat = store[rd_ptr];
endmodule

module rdmem_port_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUT    = 4,
    localparam int CW        = $clog2(MAX_OUT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req_valid,
    input  logic [ADDR_WIDTH-1:0] f_req_addr,
    output logic                  f_req_ready,
    output logic                  f_rsp_valid,
    output logic [DATA_WIDTH-1:0] f_rsp_data,
    input  logic                  m_req_valid,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_req_ready,
    output logic                  m_rsp_valid,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic [CW-1:0]         outstanding,
    output logic                  err
`ifdef RDMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_f_grants,
    output logic [31:0]           perf_m_grants,
    output logic [31:0]           perf_conflicts
`endif
);
    typedef enum logic {OWN_F = 1'b0, OWN_M = 1'b1} owner_e;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    owner_e last_grant;
    owner_e lock_owner;
    owner_e grant;
    logic   lock;
    logic   grant_vld;
    logic   not_full;
    logic   accept;
    logic   pop;
    logic   head_owner;

    always_comb begin
        grant     = OWN_F;
        grant_vld = 1'b0;
        if (lock) begin
            grant     = lock_owner;
            grant_vld = 1'b1;
        end else if (f_req_valid && m_req_valid) begin
            grant     = (last_grant == OWN_M) ? OWN_F : OWN_M;
            grant_vld = 1'b1;
        end else if (f_req_valid) begin
            grant     = OWN_F;
            grant_vld = 1'b1;
        end else if (m_req_valid) begin
            grant     = OWN_M;
            grant_vld = 1'b1;
        end
    end

    // Full blocks issue even when a pop frees a slot this same cycle.
    assign not_full      = (outstanding != MAX_CNT);
    assign mem_req_valid = grant_vld && not_full &&
                           ((grant == OWN_F) ? f_req_valid : m_req_valid);
    assign mem_req_addr  = !grant_vld ? '0 :
                           ((grant == OWN_F) ? f_req_addr : m_req_addr);
    assign f_req_ready   = grant_vld && (grant == OWN_F) && mem_req_ready && not_full;
    assign m_req_ready   = grant_vld && (grant == OWN_M) && mem_req_ready && not_full;
    assign accept        = mem_req_valid && mem_req_ready;
    assign pop           = mem_rsp_valid && (outstanding != '0);

    rdmem_owner_fifo #(.W(1), .DEPTH(MAX_OUT), .CW(CW)) u_owner_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (accept),
        .push_dat (grant == OWN_M),
        .pop_vld  (pop),
        .pop_dat  (head_owner),
        .count    (outstanding)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant  <= OWN_M;
            lock        <= 1'b0;
            lock_owner  <= OWN_F;
            f_rsp_valid <= 1'b0;
            m_rsp_valid <= 1'b0;
            f_rsp_data  <= '0;
            m_rsp_data  <= '0;
            err         <= 1'b0;
        end else begin
            if (accept) begin
                lock       <= 1'b0;
                last_grant <= grant;
            end else if (mem_req_valid) begin
                lock       <= 1'b1;
                lock_owner <= grant;
            end
            f_rsp_valid <= pop && !head_owner;
            m_rsp_valid <= pop && head_owner;
            if (pop && !head_owner) f_rsp_data <= mem_rsp_data;
            if (pop && head_owner)  m_rsp_data <= mem_rsp_data;
            if (mem_rsp_valid && (outstanding == '0)) err <= 1'b1;
        end
    end

`ifdef RDMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_f_grants  <= '0;
            perf_m_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (f_req_valid && f_req_ready) perf_f_grants <= perf_f_grants + 32'd1;
            if (m_req_valid && m_req_ready) perf_m_grants <= perf_m_grants + 32'd1;
            if (f_req_valid && m_req_valid && !(f_req_ready && m_req_ready))
                perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`else
    // No performance counters in this build.
`endif
endmodule

// File: doc/rdmem_port_arbiter.md
Name: rdmem_port_arbiter

Overview:
- Shares one single-ported, order-preserving data/instruction memory port between two requesters: the fetch unit (F) and the ReadMem pipeline stage (M).
- Arbitrates between them round-robin and tracks up to MAX_OUT in-flight reads in an owner FIFO.
- Uses the owner FIFO to route each memory response back to the requester that issued it.
- Sits between the core pipeline and the memory interface.

Parameters:
ADDR_WIDTH, 30, word address width (byte address bits [1:0] implied 2'b00)
DATA_WIDTH, 32, read data width
MAX_OUT, 4, max outstanding reads (power of 2, >=2)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
f_req_valid  in  1  fetch read request
f_req_addr  in  ADDR_WIDTH  fetch word address
f_req_ready  out  1  fetch request accepted this cycle
f_rsp_valid  out  1  fetch response valid
f_rsp_data  out  DATA_WIDTH  fetch response data
m_req_valid  in  1  ReadMem read request
m_req_addr  in  ADDR_WIDTH  ReadMem word address
m_req_ready  out  1  ReadMem request accepted
m_rsp_valid  out  1  ReadMem response valid
m_rsp_data  out  DATA_WIDTH  ReadMem response data
mem_req_valid  out  1  request to memory
mem_req_addr  out  ADDR_WIDTH  address to memory
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  memory response, in request order
mem_rsp_data  in  DATA_WIDTH  memory response data
outstanding  out  $clog2(MAX_OUT)+1  in-flight count
err  out  1  sticky: response with no outstanding request

Behaviour:
- Reset (rst=0, async): last_grant=M so F wins the first conflict; lock=0; owner FIFO empty; outstanding=0; f_rsp_valid=m_rsp_valid=0; rsp data=0; err=0.
- Handshake: a transfer occurs on a cycle with valid && ready. Requesters must hold valid and addr stable until ready.
- Grant selection (combinational):
  - lock=1: grant = locked owner.
  - Otherwise, only one valid: grant that one.
  - Otherwise, both valid: grant the requester != last_grant.
  - Otherwise: no grant.
- mem_req_valid = granted requester's valid && (outstanding < MAX_OUT).
- mem_req_addr = granted requester's addr; 0 when no grant.
- x_req_ready = (grant==x) && mem_req_ready && (outstanding < MAX_OUT).
- Lock: set when mem_req_valid && !mem_req_ready. The grant then cannot switch while memory stalls. Cleared on the accepting cycle.
- On accept: push owner bit into FIFO; last_grant <= owner.
- Full (outstanding==MAX_OUT): mem_req_valid=0 and both readies 0, even if a pop happens the same cycle. Lock is retained.
- Response routing:
  - mem_rsp_valid with FIFO non-empty: pop head.
  - Next cycle: the head's x_rsp_valid=1 with x_rsp_data=mem_rsp_data, registered, latency 1. The other requester's rsp_valid=0.
  - rsp_data holds its value when rsp_valid=0.
- Simultaneous push and pop: outstanding unchanged; FIFO pointers both advance. Pointers wrap modulo MAX_OUT.
- mem_rsp_valid with FIFO empty: response dropped, err<=1. err is cleared only by reset.
- Reset mid-operation: all in-flight tracking is discarded. Memory shares rst; responses arriving after reset set err.
- Minimum memory response latency is 1 cycle after acceptance. The same-cycle pop of an entry being pushed is never required.

Optional Feature:
RDMEM_ARB_PERF_EN:
- Defined: adds outputs perf_f_grants, perf_m_grants and perf_conflicts, each 32-bit.
  - perf_f_grants / perf_m_grants count accepted requests per requester.
  - perf_conflicts counts cycles with both req_valid high and one of them not ready.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single F request addr=0x100, mem_req_ready=1, memory returns 0xDEADBEEF 2 cycles later -> f_req_ready=1 in the request cycle; f_rsp_valid=1 with data 0xDEADBEEF one cycle after mem_rsp_valid; m_rsp_valid stays 0; outstanding goes 1 then 0.
- F and M both valid for 4 cycles, memory always ready -> grants F,M,F,M; after responses, the F/M response order matches the grants.
- M valid while mem_req_ready=0 for 3 cycles, F asserts in cycle 2 -> mem_req_addr stays M's address (lock); M accepted when ready rises; F granted next.
- Memory never responds, F issues 5 requests -> first 4 accepted, outstanding=4, f_req_ready=0 on the 5th. One mem_rsp_valid -> outstanding=3; 5th accepted the following cycle.
- mem_rsp_valid pulse with outstanding=0 -> no rsp_valid on either side; err=1 and held. Assert rst low mid-stream -> err, outstanding and rsp_valid immediately 0.
